spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
Byte-level command decoder sitting directly downstream of the SPI slave core in the Papilio SPI path. It consumes received bytes and turns each chip-select frame into one register read or write on a simple req/ack register bus. It also supplies the byte the slave shifts out on the next SPI transfer, so the host reads data back with a one-byte pipeline delay, as the loopback path does.

Parameters:
ADDR_W, 8, register address width; addresses wrap modulo 2^ADDR_W
DEVICE_ID, 8'h5A, byte returned by the ID command
ACK_TIMEOUT, 64, clk cycles to wait for reg_ack before aborting
STATUS_BYTE, 8'hA5, reply loaded after a valid command byte

Ports:
clk  in  1  system clock (27 MHz)
rst_n  in  1  synchronous reset, active-low
cs_active  in  1  CS already synchronised to clk; 1 = frame in progress
rx_data  in  8  byte received by SPI slave
rx_valid  in  1  one-cycle pulse, rx_data valid
tx_data  out  8  byte for slave to shift out on the next transfer
tx_load  out  1  one-cycle pulse, slave latches tx_data
reg_addr  out  ADDR_W  register address
reg_wdata  out  8  write data
reg_we  out  1  write request, held until reg_ack
reg_re  out  1  read request, held until reg_ack
reg_rdata  in  8  read data, valid with reg_ack
reg_ack  in  1  one-cycle completion
err_pulse  out  1  one-cycle pulse on protocol or bus error
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. tx_data=8'h00. tx_load, reg_we, reg_re, err_pulse=0. reg_addr and reg_wdata=0.
- Commands (first byte of frame): 8'h01 READ, 8'h02 WRITE, 8'h9F ID. Any other value: err_pulse, go to DISCARD.
- States: IDLE, ADDR, WDATA, WR_WAIT, RD_WAIT, DISCARD.
- IDLE: on rx_valid with cs_active=1, decode the command.
  - READ or WRITE: go to ADDR and load STATUS_BYTE (tx_load 1 cycle later).
  - ID: load DEVICE_ID, go to DISCARD.
- ADDR: on rx_valid, latch reg_addr.
  - READ: assert reg_re next cycle, go to RD_WAIT.
  - WRITE: go to WDATA and load 8'h00.
- WDATA: on rx_valid, latch reg_wdata, assert reg_we, go to WR_WAIT.
- RD_WAIT / WR_WAIT:
  - Strobe is held until the reg_ack cycle and drops the cycle after.
  - Read: tx_data <= reg_rdata with tx_load in the cycle after ack. Latency ack→tx_load is 1 cycle.
  - After completion go to DISCARD.
- Timeout: ACK_TIMEOUT cycles without ack drops the strobe and pulses err_pulse. A read then loads 8'hEE. Go to DISCARD.
- rx_valid during RD_WAIT/WR_WAIT (overrun): byte ignored, err_pulse, keep waiting.
- DISCARD: each further rx_valid loads 8'h00. No bus activity.
- cs_active=0 in any state: go to IDLE next cycle and deassert strobes the same cycle; a late ack is ignored. cs_active 0→1 does not clear tx_data.
- rx_valid with cs_active=0: ignored.
- rx_valid coincident with reg_ack: ack handled first, then the byte is handled per the new state.
- tx_load is never asserted on two consecutive cycles.

Optional Feature:
SPI_CMD_BURST_EN
- Defined:
  - After a read completes, stay in a READ_BURST sub-mode. Each next rx_valid issues a read at reg_addr+1 (wrap at 2^ADDR_W).
  - After a write completes, return to WDATA. Each next data byte writes reg_addr+1 (wrap at 2^ADDR_W).
- Undefined: exactly one transaction per frame, then DISCARD. The burst logic and the increment adder are absent.

Decomposition:
- Package spi_cmd_pkg: command opcodes (8'h01/8'h02/8'h9F), the state enum, and reply constants 8'hEE and 8'h00.
- One sub-module: spi_cmd_timeout, a loadable down-counter with start/clear/expired, reused by both wait states.

Test Plan:
- Reset: hold rst_n=0 for 3 clk → all outputs 0, busy=0; rst_n=1 mid-frame → stays IDLE until the next cs_active rise.
- Write: frame 02,10,3C, bus acks after 4 cycles → reg_we held exactly until ack, reg_addr=8'h10, reg_wdata=8'h3C; replies A5,00 loaded.
- Read: frame 01,20,00 with reg_rdata=8'h77 and ack after 2 cycles → tx_load carries A5 after the command byte, then 77 one cycle after ack.
- Error: ID frame 9F,00 → DEVICE_ID 5A loaded. Frame with command 7E → err_pulse once, tx 00 on later bytes. Read with no ack → err_pulse after 64 cycles, tx EE.
- Abort: cs_active drops during RD_WAIT → reg_re low the same cycle, IDLE next cycle; ack 3 cycles later has no effect.
- Burst (SPI_CMD_BURST_EN): frame 02,FE,11,22,33 → writes FE=11, FF=22, 00=33 (address wrap). Without the macro, only FE=11 is written.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Opcodes, FSM states and fixed reply bytes shared by the SPI command decoder.
// SPI_CMD_BURST_EN adds the read-burst state.
package spi_cmd_pkg;

  localparam logic [7:0] CMD_READ      = 8'h01;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_ID        = 8'h9F;

  localparam logic [7:0] REPLY_TIMEOUT = 8'hEE;
  localparam logic [7:0] REPLY_FILL    = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WR_WAIT,
    ST_RD_WAIT,
`ifdef SPI_CMD_BURST_EN
    ST_DISCARD,
    ST_RD_BURST
`else
    ST_DISCARD
`endif
  } state_e;

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Simple req/ack register bus between the SPI command decoder and the register file.
interface spi_cmd_decoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              reg_ack;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/spi_cmd_timeout.sv
// Loadable down-counter: start reloads LIMIT-1, expired holds once it reaches zero
// until clear or a new start.
module spi_cmd_timeout #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expired
);
  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q;
  logic          run_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      cnt_q <= CW'(LIMIT - 1);
      run_q <= 1'b1;
    end else if (clear) begin
      run_q <= 1'b0;
    end else if (run_q && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired = run_q && (cnt_q == '0);
endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns each SPI chip-select frame into one register-bus read or write and supplies
// the reply byte for the next transfer. Optional burst mode: SPI_CMD_BURST_EN.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [7:0]  DEVICE_ID   = 8'h5A,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cs_active,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_load,
  spi_cmd_decoder_if.master        bus,
  output logic                     err_pulse,
  output logic                     busy
);

  state_e            state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [7:0]        wdata_q, wdata_n;
  logic [7:0]        tx_data_q, tx_data_n;
  logic              tx_load_q, tx_load_n;
  logic              we_q, we_n;
  logic              re_q, re_n;
  logic              err_q, err_n;
  logic              is_read_q, is_read_n;
  logic              armed_q, armed_n;
  logic              load_req;
  logic [7:0]        load_val;
  logic              tmr_start, tmr_clear, tmr_expired;

  spi_cmd_timeout #(.LIMIT(ACK_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (tmr_start),
    .clear   (tmr_clear),
    .expired (tmr_expired)
  );

  // Bus completion is resolved first into state_n; the incoming byte is then
  // decoded against that updated state, so a coincident ack and byte both count.
  always_comb begin
    state_n   = state_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    we_n      = we_q;
    re_n      = re_q;
    is_read_n = is_read_q;
    err_n     = 1'b0;
    load_req  = 1'b0;
    load_val  = REPLY_FILL;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
    armed_n   = armed_q | ~cs_active;

    if (!cs_active) begin
      state_n   = ST_IDLE;
      we_n      = 1'b0;
      re_n      = 1'b0;
      tmr_clear = 1'b1;
    end else begin
      if (state_q == ST_WR_WAIT || state_q == ST_RD_WAIT) begin
        if (bus.reg_ack) begin
          we_n      = 1'b0;
          re_n      = 1'b0;
          tmr_clear = 1'b1;
          if (state_q == ST_RD_WAIT) begin
            load_req = 1'b1;
            load_val = bus.reg_rdata;
          end
`ifdef SPI_CMD_BURST_EN
          addr_n  = addr_q + ADDR_W'(1);
          state_n = (state_q == ST_RD_WAIT) ? ST_RD_BURST : ST_WDATA;
`else
          state_n = ST_DISCARD;
`endif
        end else if (tmr_expired) begin
          we_n      = 1'b0;
          re_n      = 1'b0;
          tmr_clear = 1'b1;
          err_n     = 1'b1;
          state_n   = ST_DISCARD;
          if (state_q == ST_RD_WAIT) begin
            load_req = 1'b1;
            load_val = REPLY_TIMEOUT;
          end
        end
      end

      if (rx_valid) begin
        case (state_n)
          ST_IDLE: begin
            // Only a frame whose start was observed is decoded.
            if (armed_q) begin
              case (rx_data)
                CMD_READ, CMD_WRITE: begin
                  state_n   = ST_ADDR;
                  is_read_n = (rx_data == CMD_READ);
                  load_req  = 1'b1;
                  load_val  = STATUS_BYTE;
                end
                CMD_ID: begin
                  state_n  = ST_DISCARD;
                  load_req = 1'b1;
                  load_val = DEVICE_ID;
                end
                default: begin
                  state_n = ST_DISCARD;
                  err_n   = 1'b1;
                end
              endcase
            end
          end
          ST_ADDR: begin
            addr_n = ADDR_W'(rx_data);
            if (is_read_q) begin
              re_n      = 1'b1;
              tmr_start = 1'b1;
              state_n   = ST_RD_WAIT;
            end else begin
              state_n  = ST_WDATA;
              load_req = 1'b1;
              load_val = REPLY_FILL;
            end
          end
          ST_WDATA: begin
            wdata_n   = rx_data;
            we_n      = 1'b1;
            tmr_start = 1'b1;
            state_n   = ST_WR_WAIT;
          end
          ST_WR_WAIT, ST_RD_WAIT: begin
            err_n = 1'b1;
          end
`ifdef SPI_CMD_BURST_EN
          ST_RD_BURST: begin
            re_n      = 1'b1;
            tmr_start = 1'b1;
            state_n   = ST_RD_WAIT;
          end
`endif
          ST_DISCARD: begin
            if (!load_req) begin
              load_req = 1'b1;
              load_val = REPLY_FILL;
            end
          end
          default: ;
        endcase
      end
    end

    tx_load_n = load_req && !tx_load_q;
    tx_data_n = tx_load_n ? load_val : tx_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      tx_load_q <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      err_q     <= 1'b0;
      is_read_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      tx_data_q <= tx_data_n;
      tx_load_q <= tx_load_n;
      we_q      <= we_n;
      re_q      <= re_n;
      err_q     <= err_n;
      is_read_q <= is_read_n;
      armed_q   <= armed_n;
    end
  end

  // Strobes fall in the same cycle chip-select is lost.
  assign bus.reg_we    = we_q && cs_active;
  assign bus.reg_re    = re_q && cs_active;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign tx_data       = tx_data_q;
  assign tx_load       = tx_load_q;
  assign err_pulse     = err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: expected reply bytes and bus transactions
// are queued as frames are driven and checked as the decoder produces them.
module tb_spi_cmd_decoder;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       err_pulse;
  logic       busy;

  spi_cmd_decoder_if #(.ADDR_W(8)) bif ();

  spi_cmd_decoder #(
    .ADDR_W      (8),
    .DEVICE_ID   (8'h5A),
    .ACK_TIMEOUT (64),
    .STATUS_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_active (cs_active),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .bus       (bif),
    .err_pulse (err_pulse),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   auto_ack = 1'b1;
  int   ack_delay = 2;
  int   late_ack_cycle = -1;
  int   strobe_cnt = 0;

  logic [7:0] exp_tx[$];
  bus_t       exp_bus[$];

  logic prev_load = 1'b0;
  logic prev_strobe = 1'b0;
  logic mon_strobe;
  int   strobe_len = 0;
  int   last_len = 0;
  int   err_seen = 0;
  bit   rd_pend = 1'b0;
  int   rd_ack_cyc = 0;
  int   e0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic cs_on();
    cs_active = 1'b1;
    tick(2);
  endtask

  task automatic cs_off();
    cs_active = 1'b0;
    tick(3);
  endtask

  task automatic push_bus(input logic we, input logic [7:0] addr, input logic [7:0] data);
    bus_t e;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    exp_bus.push_back(e);
  endtask

  // Register-bus responder: acks after ack_delay strobe cycles, or on a scheduled cycle.
  initial begin
    bif.reg_ack = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (bif.reg_ack) begin
        bif.reg_ack = 1'b0;
        strobe_cnt  = 0;
      end else if (cyc == late_ack_cycle) begin
        bif.reg_ack = 1'b1;
      end else if (auto_ack && (bif.reg_we || bif.reg_re)) begin
        strobe_cnt++;
        if (strobe_cnt >= ack_delay) bif.reg_ack = 1'b1;
      end else begin
        strobe_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    mon_strobe = bif.reg_we || bif.reg_re;
    if (tx_load) begin
      check_eq("tx_spacing", 32'(prev_load), 32'd0);
      if (exp_tx.size() == 0) begin
        check_eq("tx_extra", 32'(tx_data), 32'h100);
      end else begin
        check_eq("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      if (rd_pend) begin
        check_eq("rd_latency", 32'(cyc - rd_ack_cyc), 32'd1);
        rd_pend = 1'b0;
      end
    end
    if (mon_strobe && bif.reg_ack) begin
      if (exp_bus.size() == 0) begin
        check_eq("bus_extra", 32'({bif.reg_we, bif.reg_re, bif.reg_addr}), 32'hFFFF_FFFF);
      end else begin
        bus_t e;
        e = exp_bus.pop_front();
        check_eq("bus_we", 32'(bif.reg_we), 32'(e.we));
        check_eq("bus_re", 32'(bif.reg_re), 32'(!e.we));
        check_eq("bus_addr", 32'(bif.reg_addr), 32'(e.addr));
        if (e.we) check_eq("bus_wdata", 32'(bif.reg_wdata), 32'(e.data));
      end
      if (bif.reg_re) begin
        rd_pend    = 1'b1;
        rd_ack_cyc = cyc;
      end
    end
    if (mon_strobe) begin
      strobe_len++;
    end else if (prev_strobe) begin
      last_len   = strobe_len;
      strobe_len = 0;
    end
    if (err_pulse) err_seen++;
    prev_load   = tx_load;
    prev_strobe = mon_strobe;
  end

  initial begin
    rst_n         = 1'b0;
    cs_active     = 1'b1;
    rx_valid      = 1'b0;
    rx_data       = 8'h00;
    bif.reg_rdata = 8'h00;

    // Reset held mid-frame
    tick(3);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_tx_load", 32'(tx_load), 32'd0);
    check_eq("rst_we", 32'(bif.reg_we), 32'd0);
    check_eq("rst_re", 32'(bif.reg_re), 32'd0);
    check_eq("rst_addr", 32'(bif.reg_addr), 32'd0);
    check_eq("rst_wdata", 32'(bif.reg_wdata), 32'd0);
    check_eq("rst_err", 32'(err_pulse), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    send_byte(8'h02, 4);
    check_eq("midframe_idle", 32'(busy), 32'd0);
    cs_off();
    check_eq("midframe_err", 32'(err_seen), 32'd0);

    // Write 02,10,3C with ack after 4 strobe cycles
    ack_delay = 4;
    e0 = err_seen;
    cs_on();
    exp_tx.push_back(8'hA5);
    send_byte(8'h02, 8);
    check_eq("wr_busy", 32'(busy), 32'd1);
    exp_tx.push_back(8'h00);
    send_byte(8'h10, 8);
    push_bus(1'b1, 8'h10, 8'h3C);
    send_byte(8'h3C, 10);
    check_eq("wr_strobe_len", 32'(last_len), 32'd4);
    cs_off();
    check_eq("wr_err", 32'(err_seen - e0), 32'd0);

    // Read 01,20,00 with rdata 77 and ack after 2 strobe cycles
    ack_delay     = 2;
    bif.reg_rdata = 8'h77;
    e0 = err_seen;
    cs_on();
    exp_tx.push_back(8'hA5);
    send_byte(8'h01, 8);
    push_bus(1'b0, 8'h20, 8'h77);
    exp_tx.push_back(8'h77);
    send_byte(8'h20, 8);
    check_eq("rd_strobe_len", 32'(last_len), 32'd2);
    exp_tx.push_back(8'h00);
    send_byte(8'h00, 6);
    cs_off();
    check_eq("rd_err", 32'(err_seen - e0), 32'd0);

    // ID command
    e0 = err_seen;
    cs_on();
    exp_tx.push_back(8'h5A);
    send_byte(8'h9F, 8);
    exp_tx.push_back(8'h00);
    send_byte(8'h00, 6);
    cs_off();
    check_eq("id_err", 32'(err_seen - e0), 32'd0);

    // Unknown command: one error, fill bytes afterwards
    e0 = err_seen;
    cs_on();
    send_byte(8'h7E, 8);
    exp_tx.push_back(8'h00);
    send_byte(8'h11, 8);
    exp_tx.push_back(8'h00);
    send_byte(8'h22, 6);
    cs_off();
    check_eq("badcmd_err", 32'(err_seen - e0), 32'd1);

    // Read with no ack: overrun byte while waiting, then timeout
    auto_ack = 1'b0;
    e0 = err_seen;
    cs_on();
    exp_tx.push_back(8'hA5);
    send_byte(8'h01, 8);
    exp_tx.push_back(8'hEE);
    send_byte(8'h30, 10);
    send_byte(8'hAB, 5);
    check_eq("overrun_err", 32'(err_seen - e0), 32'd1);
    check_eq("overrun_re_held", 32'(bif.reg_re), 32'd1);
    tick(70);
    check_eq("timeout_re", 32'(bif.reg_re), 32'd0);
    check_eq("timeout_strobe_len", 32'(last_len), 32'd64);
    exp_tx.push_back(8'h00);
    send_byte(8'h00, 6);
    cs_off();
    check_eq("timeout_err", 32'(err_seen - e0), 32'd2);

    // Abort: CS drops while the read is outstanding, late ack ignored
    e0 = err_seen;
    cs_on();
    exp_tx.push_back(8'hA5);
    send_byte(8'h01, 8);
    send_byte(8'h40, 3);
    check_eq("abort_re_before", 32'(bif.reg_re), 32'd1);
    cs_active = 1'b0;
    #1;
    check_eq("abort_re_same_cycle", 32'(bif.reg_re), 32'd0);
    tick(1);
    check_eq("abort_idle", 32'(busy), 32'd0);
    late_ack_cycle = cyc + 3;
    tick(6);
    check_eq("abort_late_ack_busy", 32'(busy), 32'd0);
    check_eq("abort_late_ack_re", 32'(bif.reg_re), 32'd0);
    late_ack_cycle = -1;
    send_byte(8'h01, 4);
    check_eq("cs_low_byte_ignored", 32'(busy), 32'd0);
    check_eq("abort_err", 32'(err_seen - e0), 32'd0);

    // Burst write 02,FE,11,22,33 across the address wrap
    auto_ack  = 1'b1;
    ack_delay = 1;
    e0 = err_seen;
    cs_on();
    check_eq("cs_rise_keeps_tx", 32'(tx_data), 32'hA5);
    exp_tx.push_back(8'hA5);
    send_byte(8'h02, 8);
    exp_tx.push_back(8'h00);
    send_byte(8'hFE, 8);
    push_bus(1'b1, 8'hFE, 8'h11);
    send_byte(8'h11, 8);
`ifdef SPI_CMD_BURST_EN
    push_bus(1'b1, 8'hFF, 8'h22);
    send_byte(8'h22, 8);
    push_bus(1'b1, 8'h00, 8'h33);
    send_byte(8'h33, 8);
`else
    exp_tx.push_back(8'h00);
    send_byte(8'h22, 8);
    exp_tx.push_back(8'h00);
    send_byte(8'h33, 8);
`endif
    cs_off();
    check_eq("burst_err", 32'(err_seen - e0), 32'd0);

    tick(4);
    check_eq("tx_left", 32'(exp_tx.size()), 32'd0);
    check_eq("bus_left", 32'(exp_bus.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
